lcd_char_ram_arbiter: RTL and testbench
=======================================

# lcd_char_ram_arbiter

Arbiter and sequencer for the single-port character RAM behind the LCD character display (800x480 panel, 8x16 glyphs, 100x30 = 3000 cells). It serves the scan-out renderer's reads with fixed latency and absolute priority. Host writes are buffered in a small FIFO and issued in free RAM cycles. A host-triggered clear sweep fills every cell with a blank character. It sits between the LCD timing/renderer path (DEN domain) and the external synchronous RAM.

## Interface
Parameters:
- ADDR_W, 12, character RAM address width
- DATA_W, 8, character code width
- CHARS, 3000, number of valid cells (addresses 0..CHARS-1)
- FIFO_DEPTH, 4, host write queue depth (power of 2, >= 2)
- CLR_CHAR, 8'h20, code written by the clear sweep

Ports:
- CLK  in  1  single clock (panel pixel clock domain)
- RST  in  1  asynchronous, active-high reset
- DEN  in  1  display-enable from LCD timing (1 = active pixels)
- VID_REQ  in  1  renderer read request, one cycle per read
- VID_ADDR  in  ADDR_W  renderer read address
- VID_DATA  out  DATA_W  read data, registered
- VID_VALID  out  1  VID_DATA valid strobe
- HOST_VALID  in  1  host write offer
- HOST_READY  out  1  FIFO can accept
- HOST_ADDR  in  ADDR_W  host write address
- HOST_DATA  in  DATA_W  host write data
- HOST_CLR  in  1  start clear sweep (single-cycle pulse)
- BUSY  out  1  clear sweep in progress
- RAM_ADDR  out  ADDR_W  registered RAM address
- RAM_WE  out  1  registered RAM write enable
- RAM_WDATA  out  DATA_W  registered RAM write data
- RAM_RDATA  in  DATA_W  RAM read data, 1-cycle latency after RAM_ADDR

## Operation
- Reset: VID_DATA=0, VID_VALID=0, HOST_READY=0 (goes 1 on first cycle after RST release), BUSY=0, RAM_ADDR=0, RAM_WE=0, RAM_WDATA=0, FIFO empty, state IDLE.
- Per-cycle slot priority: VID_REQ > clear write > FIFO head write. Exactly one RAM access per cycle.
- FIFO: push on HOST_VALID && HOST_READY. HOST_READY = !full && !BUSY, from registered state. A pop in the same cycle does not open a slot for a push while full. Entries with HOST_ADDR >= CHARS are accepted, then discarded at pop without a RAM write.
- States: IDLE and CLEAR.
  - IDLE -> CLEAR when HOST_CLR is sampled high; the clear counter loads 0.
  - In CLEAR, each granted clear slot writes CLR_CHAR at the counter address and increments the counter.
  - After the write to CHARS-1: -> IDLE.
  - HOST_CLR while in CLEAR is ignored.
  - FIFO entries present at clear start are held and written after the sweep, so they survive the clear.
- No VID_REQ and no pending write: RAM_WE=0, RAM_ADDR holds its value.
- Asserting RST mid-operation aborts any sweep. FIFO contents are lost. Outputs return to reset values immediately.

## Timing
- Read: VID_REQ sampled at edge k -> RAM_ADDR=VID_ADDR, RAM_WE=0 after k -> RAM returns data after k+1 -> VID_DATA registered and VID_VALID=1 for one cycle after k+2. Latency is fixed at 2 edges, including back-to-back requests (one read per cycle sustained).
- Write: FIFO push at edge k -> earliest RAM_WE=1 with that entry after edge k+1, if the slot is free.
- BUSY=1 from the edge that samples HOST_CLR through the edge that issues the CHARS-1 write. BUSY=0 after the next edge.
- Uncontended clear duration: CHARS cycles.

## Configuration
- LCD_BLANK_WRITES_EN defined: clear and FIFO writes are granted only while DEN=0, so the RAM is untouched during active pixels. Reads are unaffected.
- LCD_BLANK_WRITES_EN undefined: writes take any cycle without VID_REQ, regardless of DEN.

## Test plan
- Reset/read latency: release RST, VID_REQ at addr 5 with the RAM model holding 8'h41 -> VID_VALID pulses exactly 2 edges later with VID_DATA=8'h41. Outputs are 0 during reset.
- Contention: continuous VID_REQ while the host pushes (addr 10, 8'h55) -> no RAM_WE while VID_REQ=1. Write issued in the first idle cycle, and a later read of 10 returns 8'h55.
- FIFO full: 5 consecutive pushes with no free slots -> HOST_READY drops after the 4th. The 5th is held and accepted only after one pop.
- Clear: HOST_CLR pulse with no reads -> BUSY high for 3000 cycles, cells 0..2999 read 8'h20. A push of (3, 8'h7A) queued just before HOST_CLR reads 8'h7A afterwards.
- Out-of-range and abort: push addr 3000 -> accepted, no RAM_WE. RST asserted at clear counter 1500 -> BUSY=0 immediately, cells 1500..2999 unchanged.
- LCD_BLANK_WRITES_EN build: push during DEN=1 -> RAM_WE stays 0 until the first cycle with DEN=0.

Source files
------------

// File: rtl/lcd_char_ram_arbiter.sv
// rtl/lcd_char_ram_arbiter.sv - character RAM arbiter: fixed-latency video reads, queued host writes, clear sweep
// Optional feature macro: LCD_BLANK_WRITES_EN (writes only while i_den=0)
module lcd_char_ram_arbiter #(
  parameter int              ADDR_W     = 12,
  parameter int              DATA_W     = 8,
  parameter int              CHARS      = 3000,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] CLR_CHAR = 8'h20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_den,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic [DATA_W-1:0] o_vid_data,
  output logic              o_vid_valid,
  input  logic              i_host_valid,
  output logic              o_host_ready,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_data,
  input  logic              i_host_clr,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_clr_start;

  logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]      r_wr_ptr;
  logic [PTR_W:0]      r_rd_ptr;

  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                r_busy;
  logic                r_ready_en;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_we;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_rd_p1;
  logic                r_rd_p2;
  logic [DATA_W-1:0]   r_vid_data;
  logic                r_vid_valid;

  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_wr_allow;
  logic                w_clr_slot;
  logic                w_clr_last;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_data;
  logic                w_head_in_range;

`ifdef LCD_BLANK_WRITES_EN
  assign w_wr_allow = !i_den;
`else
  logic w_unused_den;
  assign w_unused_den = i_den;
  assign w_wr_allow   = 1'b1;
`endif

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  assign w_head_addr     = r_fifo_addr[r_rd_ptr[PTR_W-1:0]];
  assign w_head_data     = r_fifo_data[r_rd_ptr[PTR_W-1:0]];
  assign w_head_in_range = ({1'b0, w_head_addr} < (ADDR_W+1)'(CHARS));

  // Readiness comes only from registered state, so a same-cycle pop never frees a slot
  assign o_host_ready = r_ready_en && !w_full && !r_busy;
  assign w_push       = i_host_valid && o_host_ready;

  // Video reads always win; queued writes wait until the sweep is finished
  assign w_clr_slot = !i_vid_req && (r_state == ST_CLEAR) && w_wr_allow;
  assign w_pop      = !i_vid_req && (r_state == ST_IDLE) && !w_empty && w_wr_allow;
  assign w_clr_last = (r_clr_cnt == ADDR_W'(CHARS - 1));

  always_comb begin
    w_state_next = r_state;
    w_clr_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_host_clr) begin
          w_state_next = ST_CLEAR;
          w_clr_start  = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (w_clr_slot && w_clr_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr[PTR_W-1:0]] <= i_host_addr;
      r_fifo_data[r_wr_ptr[PTR_W-1:0]] <= i_host_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_clr_cnt   <= '0;
      r_busy      <= 1'b0;
      r_ready_en  <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_rd_p1     <= 1'b0;
      r_rd_p2     <= 1'b0;
      r_vid_data  <= '0;
      r_vid_valid <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      // Held one edge past the final clear write so the host sees the sweep end cleanly
      r_busy     <= (r_state == ST_CLEAR) || w_clr_start;

      if (w_clr_start) begin
        r_clr_cnt <= '0;
      end else if (w_clr_slot) begin
        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      end

      if (i_vid_req) begin
        r_ram_addr <= i_vid_addr;
        r_ram_we   <= 1'b0;
      end else if (w_clr_slot) begin
        r_ram_addr  <= r_clr_cnt;
        r_ram_we    <= 1'b1;
        r_ram_wdata <= CLR_CHAR;
      end else if (w_pop && w_head_in_range) begin
        r_ram_addr  <= w_head_addr;
        r_ram_we    <= 1'b1;
        r_ram_wdata <= w_head_data;
      end else begin
        r_ram_we <= 1'b0;
      end

      r_rd_p1     <= i_vid_req;
      r_rd_p2     <= r_rd_p1;
      r_vid_valid <= r_rd_p2;
      if (r_rd_p2) begin
        r_vid_data <= i_ram_rdata;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_we    = r_ram_we;
  assign o_ram_wdata = r_ram_wdata;
  assign o_vid_data  = r_vid_data;
  assign o_vid_valid = r_vid_valid;

endmodule

// File: tb/tb_lcd_char_ram_arbiter.sv
// tb/tb_lcd_char_ram_arbiter.sv - directed bench for lcd_char_ram_arbiter with a behavioural RAM
module tb_lcd_char_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        den = 1'b0;
  logic        vid_req = 1'b0;
  logic [11:0] vid_addr = '0;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [11:0] host_addr = '0;
  logic [7:0]  host_data = '0;
  logic        host_clr = 1'b0;
  logic        busy;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;

  logic [7:0]  mem [0:4095];
  logic        mem_reload = 1'b1;

  int vectors    = 0;
  int miscompares = 0;
  int we_seen;
  int wcount;
  int bad;
  logic hit;
  logic found;

  always #5 clk = ~clk;

  lcd_char_ram_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_den        (den),
    .i_vid_req    (vid_req),
    .i_vid_addr   (vid_addr),
    .o_vid_data   (vid_data),
    .o_vid_valid  (vid_valid),
    .i_host_valid (host_valid),
    .o_host_ready (host_ready),
    .i_host_addr  (host_addr),
    .i_host_data  (host_data),
    .i_host_clr   (host_clr),
    .o_busy       (busy),
    .o_ram_addr   (ram_addr),
    .o_ram_we     (ram_we),
    .o_ram_wdata  (ram_wdata),
    .i_ram_rdata  (ram_rdata)
  );

  function automatic logic [7:0] pat(int i);
    if (i == 5) return 8'h41;
    return 8'(i * 7);
  endfunction

  always @(posedge clk) begin
    if (mem_reload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    mem_reload = 1'b0;
    chk("rst_vid_data", 32'(vid_data), 32'h0);
    chk("rst_vid_valid", 32'(vid_valid), 32'h0);
    chk("rst_host_ready", 32'(host_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(host_ready), 32'h1);

    // Read latency: address 5 holds 8'h41
    vid_req = 1'b1; vid_addr = 12'd5;
    tick();
    vid_req = 1'b0;
    chk("rd_ram_addr", 32'(ram_addr), 32'd5);
    chk("rd_ram_we", 32'(ram_we), 32'h0);
    tick();
    chk("rd_valid_early", 32'(vid_valid), 32'h0);
    tick();
    chk("rd_valid", 32'(vid_valid), 32'h1);
    chk("rd_data", 32'(vid_data), 32'h41);
    tick();
    chk("rd_valid_single", 32'(vid_valid), 32'h0);

    // Back-to-back reads: 6*7=0x2A, 7*7=0x31
    vid_req = 1'b1; vid_addr = 12'd6;
    tick();
    vid_addr = 12'd7;
    tick();
    vid_req = 1'b0;
    tick();
    chk("b2b_valid0", 32'(vid_valid), 32'h1);
    chk("b2b_data0", 32'(vid_data), 32'h2A);
    tick();
    chk("b2b_valid1", 32'(vid_valid), 32'h1);
    chk("b2b_data1", 32'(vid_data), 32'h31);
    tick();
    chk("b2b_valid_end", 32'(vid_valid), 32'h0);

    // Contention: host write waits for a cycle without a read
    vid_req = 1'b1; vid_addr = 12'd0;
    host_valid = 1'b1; host_addr = 12'd10; host_data = 8'h55;
    tick();
    host_valid = 1'b0;
    we_seen = 0;
    repeat (5) begin
      tick();
      if (ram_we) we_seen++;
    end
    chk("cont_no_we", 32'(we_seen), 32'd0);
    vid_req = 1'b0;
    tick();
    chk("cont_we", 32'(ram_we), 32'h1);
    chk("cont_addr", 32'(ram_addr), 32'd10);
    chk("cont_wdata", 32'(ram_wdata), 32'h55);
    tick();
    chk("idle_we", 32'(ram_we), 32'h0);
    chk("idle_addr_hold", 32'(ram_addr), 32'd10);
    vid_req = 1'b1; vid_addr = 12'd10;
    tick();
    vid_req = 1'b0;
    tick();
    tick();
    chk("cont_readback_valid", 32'(vid_valid), 32'h1);
    chk("cont_readback", 32'(vid_data), 32'h55);

    // FIFO full under continuous reads
    vid_req = 1'b1; vid_addr = 12'd0;
    for (int i = 0; i < 4; i++) begin
      host_valid = 1'b1; host_addr = 12'(20 + i); host_data = 8'(8'h60 + i);
      chk("full_ready_before", 32'(host_ready), 32'h1);
      tick();
    end
    host_addr = 12'd24; host_data = 8'h64;
    chk("full_ready_low", 32'(host_ready), 32'h0);
    tick();
    tick();
    chk("full_held", 32'(host_ready), 32'h0);
    vid_req = 1'b0;
    tick();
    vid_req = 1'b1;
    chk("full_pop_we", 32'(ram_we), 32'h1);
    chk("full_pop_addr", 32'(ram_addr), 32'd20);
    chk("full_ready_after_pop", 32'(host_ready), 32'h1);
    tick();
    host_valid = 1'b0;
    chk("full_again", 32'(host_ready), 32'h0);
    vid_req = 1'b0;
    repeat (8) tick();
    for (int i = 20; i < 25; i++) begin
      chk("full_drain_mem", 32'(mem[i]), 32'(8'h60 + (i - 20)));
    end

    // Out-of-range entry is consumed without a RAM write
    host_valid = 1'b1; host_addr = 12'd3000; host_data = 8'h99;
    tick();
    host_valid = 1'b0;
    we_seen = 0;
    repeat (4) begin
      tick();
      if (ram_we) we_seen++;
    end
    chk("oor_no_we", 32'(we_seen), 32'd0);
    chk("oor_ready", 32'(host_ready), 32'h1);

    // Clear sweep with an entry queued just before it
    vid_req = 1'b1;
    host_valid = 1'b1; host_addr = 12'd3; host_data = 8'h7A;
    tick();
    host_valid = 1'b0;
    host_clr = 1'b1;
    tick();
    host_clr = 1'b0;
    vid_req = 1'b0;
    chk("clr_busy", 32'(busy), 32'h1);
    chk("clr_ready_low", 32'(host_ready), 32'h0);
    wcount = 0; hit = 1'b0;
    for (int n = 0; n < 4000 && !hit; n++) begin
      tick();
      if (ram_we && busy) wcount++;
      if (ram_we && ram_addr == 12'd2999 && ram_wdata == 8'h20) begin
        hit = 1'b1;
        chk("clr_busy_at_last", 32'(busy), 32'h1);
        tick();
        chk("clr_busy_done", 32'(busy), 32'h0);
        chk("clr_fifo_we", 32'(ram_we), 32'h1);
        chk("clr_fifo_addr", 32'(ram_addr), 32'd3);
        chk("clr_fifo_wdata", 32'(ram_wdata), 32'h7A);
      end
    end
    chk("clr_finished", 32'(hit), 32'h1);
    chk("clr_write_count", 32'(wcount), 32'd3000);
    repeat (3) tick();
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i != 3 && mem[i] !== 8'h20) bad++;
    end
    chk("clr_cells_blank", 32'(bad), 32'd0);
    chk("clr_cell3_kept", 32'(mem[3]), 32'h7A);
    chk("clr_cell3000_untouched", 32'(mem[3000]), 32'h08);
    vid_req = 1'b1; vid_addr = 12'd2999;
    tick();
    vid_req = 1'b0;
    tick();
    tick();
    chk("clr_readback", 32'(vid_data), 32'h20);

    // Reset aborts a sweep at counter 1500
    mem_reload = 1'b1;
    tick();
    mem_reload = 1'b0;
    host_clr = 1'b1;
    tick();
    host_clr = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      tick();
      if (ram_we && ram_addr == 12'd1499) found = 1'b1;
    end
    chk("abort_reached", 32'(found), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_we", 32'(ram_we), 32'h0);
    chk("abort_ready", 32'(host_ready), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("abort_busy_after", 32'(busy), 32'h0);
    chk("abort_ready_after", 32'(host_ready), 32'h1);
    bad = 0;
    for (int i = 1500; i < 3000; i++) begin
      if (mem[i] !== pat(i)) bad++;
    end
    chk("abort_cells_untouched", 32'(bad), 32'd0);
    chk("abort_cell1500", 32'(mem[1500]), 32'h04);
    chk("abort_cell1498", 32'(mem[1498]), 32'h20);

    // Write during active pixels
    den = 1'b1;
    host_valid = 1'b1; host_addr = 12'd40; host_data = 8'h33;
    tick();
    host_valid = 1'b0;
    tick();
`ifdef LCD_BLANK_WRITES_EN
    chk("den_hold0", 32'(ram_we), 32'h0);
    tick();
    chk("den_hold1", 32'(ram_we), 32'h0);
    den = 1'b0;
    tick();
`endif
    chk("den_we", 32'(ram_we), 32'h1);
    chk("den_addr", 32'(ram_addr), 32'd40);
    chk("den_wdata", 32'(ram_wdata), 32'h33);
    den = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
